// File: rtl/fifo_pkg.sv
// Shared constants and types for the circular FIFO.
package fifo_pkg;

  localparam int unsigned DEFAULT_B = 8;
  localparam int unsigned DEFAULT_W = 4;
  localparam int unsigned DEPTH     = 2 ** DEFAULT_W;

  // Accepted-operation encoding: {write accepted, read accepted}.
  typedef enum logic [1:0] {
    OP_IDLE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10,
    OP_BOTH  = 2'b11
  } op_e;

endpackage : fifo_pkg

// File: rtl/fifo_reg_file.sv
// Storage array for the circular FIFO: 2**W words of B bits.
// Ports:
//   clk     - clock, writes on rising edge
//   reset   - async active-low, clears every entry to 0
//   wr_en   - write strobe
//   w_addr  - write address
//   w_data  - write data
//   r_addr  - read address
//   r_data  - combinational read of mem[r_addr]
module fifo_reg_file
  import fifo_pkg::*;
#(
  parameter int unsigned B = DEFAULT_B,
  parameter int unsigned W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] w_addr,
  input  logic [B-1:0] w_data,
  input  logic [W-1:0] r_addr,
  output logic [B-1:0] r_data
);

  localparam int unsigned NUM_WORDS = 2 ** W;

  logic [B-1:0] mem [NUM_WORDS];

  // Storage write with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_WORDS; i++) begin
        mem[W'(i)] <= '0;
      end
    end else if (wr_en) begin
      mem[w_addr] <= w_data;
    end
  end

  assign r_data = mem[r_addr];

endmodule : fifo_reg_file

// File: rtl/circular_fifo.sv
// Circular-buffer FIFO with first-word-fall-through read data.
// Ports:
//   clk     - clock
//   reset   - async active-low reset; clears pointers, flags and storage
//   rd      - pop request (ignored while empty)
//   wr      - push request (ignored while full unless rd is also set)
//   w_data  - push data
//   empty   - registered, no stored words
//   full    - registered, 2**W stored words
//   r_data  - oldest stored word (stale when empty)
module circular_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned B = DEFAULT_B,
  parameter int unsigned W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  output logic         empty,
  output logic         full,
  output logic [B-1:0] r_data
);

  logic [W-1:0] w_ptr, w_ptr_next, w_ptr_inc;
  logic [W-1:0] r_ptr, r_ptr_next, r_ptr_inc;
  logic         empty_reg, empty_next;
  logic         full_reg, full_next;
  logic         wr_ok, rd_ok;
  op_e          op;

  // A full FIFO still takes a write when a pop happens in the same cycle:
  // the slot being overwritten is the one being popped.
  assign rd_ok = rd && !empty_reg;
  assign wr_ok = wr && (!full_reg || rd);
  assign op    = op_e'({wr_ok, rd_ok});

  assign w_ptr_inc = w_ptr + W'(1);
  assign r_ptr_inc = r_ptr + W'(1);

  // Pointer and flag next-state.
  always_comb begin
    w_ptr_next = w_ptr;
    r_ptr_next = r_ptr;
    empty_next = empty_reg;
    full_next  = full_reg;
    unique case (op)
      OP_WRITE: begin
        w_ptr_next = w_ptr_inc;
        empty_next = 1'b0;
        full_next  = (w_ptr_inc == r_ptr);
      end
      OP_READ: begin
        r_ptr_next = r_ptr_inc;
        full_next  = 1'b0;
        empty_next = (r_ptr_inc == w_ptr);
      end
      OP_BOTH: begin
        w_ptr_next = w_ptr_inc;
        r_ptr_next = r_ptr_inc;
      end
      default: ;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      empty_reg <= 1'b1;
      full_reg  <= 1'b0;
    end else begin
      w_ptr     <= w_ptr_next;
      r_ptr     <= r_ptr_next;
      empty_reg <= empty_next;
      full_reg  <= full_next;
    end
  end

  assign empty = empty_reg;
  assign full  = full_reg;

  fifo_reg_file #(
    .B (B),
    .W (W)
  ) u_reg_file (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_ok),
    .w_addr (w_ptr),
    .w_data (w_data),
    .r_addr (r_ptr),
    .r_data (r_data)
  );

endmodule : circular_fifo

// File: tb/tb_circular_fifo.sv
// Directed bench for circular_fifo: vector table plus multi-cycle sequences.
module tb_circular_fifo;

  logic       clk;
  logic       reset;
  logic       rd;
  logic       wr;
  logic [7:0] w_data;
  logic       empty;
  logic       full;
  logic [7:0] r_data;

  int n_tests;
  int n_fail;

  circular_fifo #(.B(8), .W(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .w_data (w_data),
    .empty  (empty),
    .full   (full),
    .r_data (r_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       wr;
    logic       rd;
    logic [7:0] din;
    logic       exp_empty;
    logic       exp_full;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic e, input logic f, input logic [7:0] d);
    check({name, ".empty"}, 8'(empty), 8'(e));
    check({name, ".full"}, 8'(full), 8'(f));
    check({name, ".r_data"}, r_data, d);
  endtask

  // Drive one cycle of inputs between edges, sample 1 time unit after the edge.
  task automatic step(input logic rst_v, input logic wr_v, input logic rd_v, input logic [7:0] d);
    @(negedge clk);
    reset  = rst_v;
    wr     = wr_v;
    rd     = rd_v;
    w_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    w_data  = 8'h00;

    //             rst   wr    rd    din    empty full  r_data
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00}; // reset
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00}; // reset
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00}; // idle
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00}; // idle
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 8'h01}; // single write
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00}; // read; stale mem[1]=0
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 8'h01}; // stream 1
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 8'h01}; // stream 1
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 8'h01}; // stream 1
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h02, 1'b0, 1'b0, 8'h01}; // stream 2
    vecs[10] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h01}; // pop -> next 1
    vecs[11] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h01}; // pop -> next 1
    vecs[12] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h02}; // pop -> next 2
    vecs[13] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00}; // last pop, empty
    vecs[14] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00}; // read while empty ignored
    vecs[15] = '{1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 8'h33}; // rd+wr while empty: write only
    vecs[16] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 8'h00}; // pop it back out

    for (int i = 0; i < 17; i++) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
      check_all($sformatf("vec%0d", i), vecs[i].exp_empty, vecs[i].exp_full, vecs[i].exp_data);
    end

    // Fill to full, overflow, drain.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b0, 8'(i));
      check_all($sformatf("fill%0d", i), 1'b0, (i == 15), 8'h00);
    end
    step(1'b1, 1'b1, 1'b0, 8'hAA);
    check_all("overflow", 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_data%0d", i), r_data, 8'(i));
      step(1'b1, 1'b0, 1'b1, 8'h00);
      check($sformatf("drain_full%0d", i), 8'(full), 8'h00);
    end
    check("drain_empty", 8'(empty), 8'h01);

    // Wrap-around with a second batch, then simultaneous ops at full and empty.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h10 + i));
    for (int i = 0; i < 10; i++) begin
      check($sformatf("b1_data%0d", i), r_data, 8'(8'h10 + i));
      step(1'b1, 1'b0, 1'b1, 8'h00);
    end
    check("b1_empty", 8'(empty), 8'h01);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h20 + i));
    check_all("b2_head", 1'b0, 1'b0, 8'h20);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h30 + i));
    check_all("wrap_full", 1'b0, 1'b1, 8'h20);
    step(1'b1, 1'b1, 1'b1, 8'h77);
    check_all("full_rdwr", 1'b0, 1'b1, 8'h21);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_d;
      if (i < 9)       exp_d = 8'(8'h21 + i);
      else if (i < 15) exp_d = 8'(8'h30 + (i - 9));
      else             exp_d = 8'h77;
      check($sformatf("wrap_data%0d", i), r_data, exp_d);
      step(1'b1, 1'b0, 1'b1, 8'h00);
    end
    check_all("wrap_empty", 1'b1, 1'b0, r_data);
    step(1'b1, 1'b1, 1'b1, 8'h55);
    check_all("empty_rdwr", 1'b0, 1'b0, 8'h55);

    // Asynchronous reset between clock edges.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 8'(8'hC0 + i));
    check_all("pre_rst", 1'b0, 1'b0, 8'hC0);
    @(negedge clk);
    wr = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all("async_rst", 1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    check_all("post_rst", 1'b1, 1'b0, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_circular_fifo
